// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and data memory (slave).
interface mem_wb_stage_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM + WB stage: variable-latency load/store with timeout abort, upstream freeze,
// and the MEM/WB register that feeds the register-file write port.
module mem_wb_stage #(
   parameter int unsigned BASE_ADDR = 1024,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  WB_EN,
   input  logic                  MEM_R_EN,
   input  logic                  MEM_W_EN,
   input  logic [31:0]           ALU_result,
   input  logic [31:0]           Val_RM,
   input  logic [3:0]            Dest,
   mem_wb_stage_if.master        mem,
   output logic                  freeze,
   output logic [3:0]            Dest_wb,
   output logic [31:0]           Result_WB,
   output logic                  writeBackEn,
   output logic                  mem_err,
   output logic                  align_err
);

   localparam logic [31:0] BaseAddr   = 32'(BASE_ADDR);
   localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StWait, StAbort} state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       access;
   logic       abort_hit;
   logic       align_hit;

   assign access = MEM_R_EN | MEM_W_EN;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      abort_hit = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (access && !mem.mem_ready) begin
               state_d = StWait;
               cnt_d   = 8'd1;
            end
         end
         StWait: begin
            if (mem.mem_ready) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == TimeoutCnt) begin
               state_d   = StAbort;
               cnt_d     = '0;
               abort_hit = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StAbort: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs; the aligned word address simply drops the low byte-offset bits
   always_comb begin
      mem.mem_req   = access && (state_q != StAbort);
      mem.mem_we    = MEM_W_EN && !MEM_R_EN;
      mem.mem_wdata = Val_RM;
      mem.mem_addr  = ADDR_W'((ALU_result - BaseAddr) >> 2);
      freeze        = access && !mem.mem_ready && (state_q != StAbort);
      align_hit     = access && mem.mem_req && (ALU_result[1:0] != 2'b00);
   end

   // MEM/WB pipeline register and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         Dest_wb     <= '0;
         Result_WB   <= '0;
         writeBackEn <= 1'b0;
         mem_err     <= 1'b0;
         align_err   <= 1'b0;
      end else begin
         if (freeze || (state_q == StAbort)) begin
            writeBackEn <= 1'b0;
         end else begin
            Dest_wb     <= Dest;
            Result_WB   <= MEM_R_EN ? mem.mem_rdata : ALU_result;
            writeBackEn <= WB_EN && !mem.mem_we;
         end
         if (abort_hit) mem_err   <= 1'b1;
         if (align_hit) align_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: transaction-level model checked every cycle, plus literal pins.
module tb_mem_wb_stage;
   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        WB_EN = 1'b0, MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
   logic [31:0] ALU_result = '0, Val_RM = '0;
   logic [3:0]  Dest = '0;
   logic        freeze, writeBackEn, mem_err, align_err;
   logic [3:0]  Dest_wb;
   logic [31:0] Result_WB;

   mem_wb_stage_if #(.ADDR_W(8)) mem_bus ();

   mem_wb_stage dut (
      .clk        (clk),
      .rst        (rst),
      .WB_EN      (WB_EN),
      .MEM_R_EN   (MEM_R_EN),
      .MEM_W_EN   (MEM_W_EN),
      .ALU_result (ALU_result),
      .Val_RM     (Val_RM),
      .Dest       (Dest),
      .mem        (mem_bus),
      .freeze     (freeze),
      .Dest_wb    (Dest_wb),
      .Result_WB  (Result_WB),
      .writeBackEn(writeBackEn),
      .mem_err    (mem_err),
      .align_err  (align_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model expectations
   logic        check_en = 1'b0;
   logic        exp_freeze = 0, exp_req = 0, exp_we = 0;
   logic [7:0]  exp_addr = '0;
   logic [31:0] exp_wdata = '0;
   logic        exp_wben = 0, exp_mem_err = 0, exp_align = 0;
   logic [3:0]  exp_dest = '0;
   logic [31:0] exp_res = '0;

   // Observation counters for literal pins
   int          fz_cnt = 0, wb_cnt = 0;
   logic [7:0]  last_addr = '0;
   logic        last_we = 0;
   logic [31:0] last_wdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (freeze) fz_cnt++;
      if (writeBackEn) wb_cnt++;
      if (mem_bus.mem_req) begin
         last_addr  = mem_bus.mem_addr;
         last_we    = mem_bus.mem_we;
         last_wdata = mem_bus.mem_wdata;
      end
      if (check_en) begin
         chk("freeze", {31'b0, freeze}, {31'b0, exp_freeze});
         chk("mem_req", {31'b0, mem_bus.mem_req}, {31'b0, exp_req});
         chk("mem_we", {31'b0, mem_bus.mem_we}, {31'b0, exp_we});
         chk("mem_addr", {24'b0, mem_bus.mem_addr}, {24'b0, exp_addr});
         chk("mem_wdata", mem_bus.mem_wdata, exp_wdata);
         chk("writeBackEn", {31'b0, writeBackEn}, {31'b0, exp_wben});
         chk("Dest_wb", {28'b0, Dest_wb}, {28'b0, exp_dest});
         chk("Result_WB", Result_WB, exp_res);
         chk("mem_err", {31'b0, mem_err}, {31'b0, exp_mem_err});
         chk("align_err", {31'b0, align_err}, {31'b0, exp_align});
      end
   end

   // One instruction: lat = cycles until mem_ready (lat > TO means the memory never answers in time)
   task automatic issue(input logic wb, input logic r, input logic w, input logic [31:0] alu,
                        input logic [31:0] val, input logic [3:0] dst, input int lat,
                        input logic [31:0] rd);
      logic acc;
      int   total;
      logic abort_cyc;
      acc   = r | w;
      total = !acc ? 1 : (lat > TO ? TO + 2 : lat + 1);
      for (int k = 0; k < total; k++) begin
         WB_EN = wb; MEM_R_EN = r; MEM_W_EN = w;
         ALU_result = alu; Val_RM = val; Dest = dst;
         mem_bus.mem_ready = acc && (k == lat);
         mem_bus.mem_rdata = (k == lat) ? rd : 32'hDEAD_BEEF;
         abort_cyc  = acc && (lat > TO) && (k == TO + 1);
         exp_freeze = acc && (k < lat) && !abort_cyc;
         exp_req    = acc && !abort_cyc;
         exp_we     = w && !r;
         exp_addr   = 8'((alu - 32'd1024) / 4);
         exp_wdata  = val;
         @(posedge clk); #1;
         if (abort_cyc || exp_freeze) begin
            exp_wben = 1'b0;
         end else begin
            exp_wben = wb && !(w && !r);
            exp_dest = dst;
            exp_res  = r ? rd : alu;
         end
         if (acc && (lat > TO) && (k == TO)) exp_mem_err = 1'b1;
         if (exp_req && (alu[1:0] != 2'b00)) exp_align = 1'b1;
      end
   endtask

   task automatic nop();
      issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
   endtask

   task automatic clear_counts();
      fz_cnt = 0;
      wb_cnt = 0;
   endtask

   initial begin
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst Dest_wb", {28'b0, Dest_wb}, 32'h0);
      chk("rst Result_WB", Result_WB, 32'h0);
      chk("rst writeBackEn", {31'b0, writeBackEn}, 32'h0);
      chk("rst mem_err", {31'b0, mem_err}, 32'h0);
      chk("rst align_err", {31'b0, align_err}, 32'h0);
      rst = 1'b0;
      check_en = 1'b1;

      // ALU passthrough
      clear_counts();
      issue(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 4'd5, 0, 32'h0);
      chk("pass wben", {31'b0, writeBackEn}, 32'h1);
      chk("pass dest", {28'b0, Dest_wb}, 32'h5);
      chk("pass result", Result_WB, 32'h1234);
      chk("pass freeze cycles", fz_cnt, 0);

      // 0-wait load
      clear_counts();
      issue(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd2, 0, 32'hCAFE);
      chk("load0 addr", {24'b0, last_addr}, 32'd1);
      chk("load0 freeze cycles", fz_cnt, 0);
      chk("load0 result", Result_WB, 32'hCAFE);
      chk("load0 wben", {31'b0, writeBackEn}, 32'h1);

      // 3-wait store with WB_EN set
      nop();
      clear_counts();
      issue(1'b1, 1'b0, 1'b1, 32'd1032, 32'd7, 4'd9, 3, 32'h0);
      nop();
      chk("store addr", {24'b0, last_addr}, 32'd2);
      chk("store we", {31'b0, last_we}, 32'h1);
      chk("store wdata", last_wdata, 32'd7);
      chk("store freeze cycles", fz_cnt, 3);
      chk("store writebacks", wb_cnt, 0);

      // 2-wait load then ALU op
      clear_counts();
      issue(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd1, 2, 32'h0000_BEEF);
      chk("ld2 result", Result_WB, 32'h0000_BEEF);
      chk("ld2 dest", {28'b0, Dest_wb}, 32'd1);
      issue(1'b1, 1'b0, 1'b0, 32'h0000_0042, 32'h0, 4'd6, 0, 32'h0);
      chk("alu after ld result", Result_WB, 32'h42);
      chk("alu after ld dest", {28'b0, Dest_wb}, 32'd6);
      nop();
      chk("ld+alu writebacks", wb_cnt, 2);
      chk("ld+alu freeze cycles", fz_cnt, 2);

      // Timeout; mem_ready arrives during the abort cycle and must be ignored
      clear_counts();
      issue(1'b1, 1'b1, 1'b0, 32'd1044, 32'h0, 4'd4, TO + 1, 32'h1111_1111);
      chk("timeout wben", {31'b0, writeBackEn}, 32'h0);
      chk("timeout mem_err", {31'b0, mem_err}, 32'h1);
      nop();
      chk("timeout freeze cycles", fz_cnt, 16);
      chk("timeout writebacks", wb_cnt, 0);
      clear_counts();
      issue(1'b1, 1'b1, 1'b0, 32'd1048, 32'h0, 4'd8, 1, 32'h55);
      chk("post-timeout result", Result_WB, 32'h55);
      chk("post-timeout freeze cycles", fz_cnt, 1);
      chk("mem_err sticky", {31'b0, mem_err}, 32'h1);

      // Misaligned load, then reset during WAIT
      issue(1'b1, 1'b1, 1'b0, 32'd1025, 32'h0, 4'd3, 0, 32'h77);
      chk("misalign addr", {24'b0, last_addr}, 32'd0);
      chk("misalign align_err", {31'b0, align_err}, 32'h1);
      check_en = 1'b0;
      WB_EN = 1'b1; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0;
      ALU_result = 32'd1028; Dest = 4'd3;
      mem_bus.mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      WB_EN = 1'b0; MEM_R_EN = 1'b0; ALU_result = '0; Dest = '0;
      @(posedge clk); #1;
      chk("midrst Dest_wb", {28'b0, Dest_wb}, 32'h0);
      chk("midrst Result_WB", Result_WB, 32'h0);
      chk("midrst writeBackEn", {31'b0, writeBackEn}, 32'h0);
      chk("midrst mem_err", {31'b0, mem_err}, 32'h0);
      chk("midrst align_err", {31'b0, align_err}, 32'h0);
      chk("midrst freeze", {31'b0, freeze}, 32'h0);
      rst = 1'b0;
      exp_wben = 0; exp_dest = '0; exp_res = '0; exp_mem_err = 0; exp_align = 0;
      check_en = 1'b1;
      clear_counts();
      issue(1'b1, 1'b1, 1'b0, 32'd1052, 32'h0, 4'd7, 1, 32'hA5A5);
      chk("post-rst freeze cycles", fz_cnt, 1);
      chk("post-rst result", Result_WB, 32'hA5A5);
      chk("post-rst wben", {31'b0, writeBackEn}, 32'h1);
      nop();
      check_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
